// File: rtl/rv32m_multicycle_muldiv_if.sv
`default_nettype none
// ============================================================================
// rv32m_multicycle_muldiv_if
// Request/response handshake bundle for the iterative RV32M mul/div unit.
// Revision: 1.0
// ============================================================================
interface rv32m_multicycle_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, funct3, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/rv32m_multicycle_muldiv.sv
`default_nettype none
// ============================================================================
// rv32m_multicycle_muldiv
// Radix-2 iterative RV32M multiply/divide unit, one operand bit per cycle.
// Optional: MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is spent.
// Revision: 1.0
// ============================================================================
module rv32m_multicycle_muldiv #(
    parameter int XLEN = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                ena,
    rv32m_multicycle_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_op;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;   // product accumulator / remainder (low half) / fast result
    logic [2*XLEN-1:0] r_sh;    // multiplicand shifting left / divisor (low half)
    logic [XLEN-1:0]   r_lo;    // multiplier shifting right / dividend becoming quotient
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Request decode, operand magnitudes and special cases
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_in_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_res_neg;

    assign w_accept   = ena & bus.in_valid & (r_state == S_IDLE);
    assign w_in_div   = bus.funct3[2];
    assign w_a_signed = (bus.funct3 == c_F3_MULH) | (bus.funct3 == c_F3_MULHSU) |
                        (bus.funct3 == c_F3_DIV)  | (bus.funct3 == c_F3_REM);
    assign w_b_signed = (bus.funct3 == c_F3_MULH) | (bus.funct3 == c_F3_DIV) |
                        (bus.funct3 == c_F3_REM);
    assign w_a_neg    = w_a_signed & bus.a[XLEN-1];
    assign w_b_neg    = w_b_signed & bus.b[XLEN-1];
    assign w_mag_a    = w_a_neg ? -bus.a : bus.a;
    assign w_mag_b    = w_b_neg ? -bus.b : bus.b;

    assign w_b_zero   = (bus.b == {XLEN{1'b0}});
    assign w_ovf      = (bus.funct3 == c_F3_DIV || bus.funct3 == c_F3_REM) &&
                        (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    assign w_special  = w_in_div & (w_b_zero | w_ovf);
    // funct3[1] separates REM* from DIV* among the divide ops
    assign w_fast_res = w_b_zero ? (bus.funct3[1] ? bus.a : {XLEN{1'b1}})
                                 : (bus.funct3[1] ? {XLEN{1'b0}} : bus.a);

    // REM follows the dividend only; everything else (MULHSU included, since
    // its b is never negative here) negates when the operand signs differ.
    assign w_res_neg  = (bus.funct3 == c_F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // ------------------------------------------------------------------
    // One iteration of the unsigned core
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_trial;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_pick;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_calc_res;
    logic              w_early;
    logic              w_last;

    assign w_mul_acc  = r_acc + (r_lo[0] ? r_sh : {(2*XLEN){1'b0}});

    assign w_trial    = {r_acc[XLEN-1:0], r_lo[XLEN-1]} - {1'b0, r_sh[XLEN-1:0]};
    assign w_qbit     = ~w_trial[XLEN];
    // Without a subtraction the shifted remainder is below the divisor, so
    // dropping r_acc[XLEN-1] loses nothing.
    assign w_rem_next = w_qbit ? w_trial[XLEN-1:0] : {r_acc[XLEN-2:0], r_lo[XLEN-1]};
    assign w_quo_next = {r_lo[XLEN-2:0], w_qbit};

    assign w_prod_fix = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_div_pick = r_op[1] ? w_rem_next : w_quo_next;
    assign w_div_fix  = r_neg ? -w_div_pick : w_div_pick;
    assign w_calc_res = r_op[2] ? w_div_fix
                      : ((r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                              : w_prod_fix[2*XLEN-1:XLEN]);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = ~r_op[2] & (r_lo[XLEN-1:1] == {(XLEN-1){1'b0}});
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(1)) | w_early;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        w_state_next = w_special ? S_FAST : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end
                end
                S_FAST: w_state_next = S_DONE;
                S_DONE: begin
                    if (bus.out_ready) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 3'b000;
            r_neg    <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_sh     <= {(2*XLEN){1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.funct3;
                        r_neg <= w_res_neg;
                        r_cnt <= CNT_W'(XLEN);
                        r_acc <= w_special ? {{XLEN{1'b0}}, w_fast_res} : {(2*XLEN){1'b0}};
                        r_sh  <= {{XLEN{1'b0}}, (w_in_div ? w_mag_b : w_mag_a)};
                        r_lo  <= w_in_div ? w_mag_a : w_mag_b;
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        r_acc <= {{XLEN{1'b0}}, w_rem_next};
                        r_lo  <= w_quo_next;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_sh  <= r_sh << 1;
                        r_lo  <= r_lo >> 1;
                    end
                    r_cnt <= w_last ? {CNT_W{1'b0}} : (r_cnt - CNT_W'(1));
                    if (w_last) begin
                        r_result <= w_calc_res;
                    end
                end
                S_FAST: r_result <= r_acc[XLEN-1:0];
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: doc/rv32m_multicycle_muldiv.md
Name: rv32m_multicycle_muldiv

Overview:
Iterative RV32M multiply/divide execution unit, parametrised in datapath width. The multicycle core's S_EXECUTE_R state hands it OP_RTYPE instructions with funct7 = 0000001 and stalls until the result returns; the result is then written back via the ALU_LAST path. It uses a valid/ready handshake on both sides and processes one operation at a time, radix-2, one bit per cycle.

Parameters:
XLEN, 32, operand/result width; legal values are >= 4.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ena  in  1  global advance enable; when low, all state holds
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
result  out  XLEN  registered result
busy  out  1  state != S_IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On reset, in any state including mid-operation:
  - state = S_IDLE
  - out_valid = 0, result = 0, busy = 0, in_ready = 1
  - counter and partial registers = 0
  - the in-flight operation is discarded.
- Every register updates only when ena = 1. When ena = 0, outputs hold and no handshake completes.
- in_ready = (state == S_IDLE). A request is accepted on an edge where in_valid & in_ready & ena. On acceptance, funct3, a and b are latched; the inputs are don't-care afterwards.
- States:
  - S_IDLE: on accept, go to S_FAST if the op is a special case, else go to S_CALC with counter = XLEN.
  - S_CALC: one iteration per enabled edge, counter decrements. At counter == 1, apply sign correction, load result, go to S_DONE.
  - S_FAST: load the special-case result, go to S_DONE.
  - S_DONE: out_valid = 1. When out_ready & ena, go to S_IDLE and clear out_valid. result holds its value until the next load.
- Latency, counting enabled edges from the acceptance edge to the first cycle out_valid = 1:
  - normal: XLEN + 1
  - special case: 2
- No back-to-back overlap: a new request is never accepted in the same edge that a result is consumed.
- Special cases (S_FAST):
  - DIV/DIVU with b = 0: result = all ones.
  - REM/REMU with b = 0: result = a.
  - DIV with a = 100..0 and b = all ones (signed overflow): result = a.
  - REM with the same operands: result = 0.
- Arithmetic:
  - Signed operands are converted to magnitudes; the unsigned core iterates on the magnitudes.
  - MULHSU treats a as signed and b as unsigned.
  - MUL* builds a 2*XLEN product. MUL returns [XLEN-1:0]; MULH, MULHSU and MULHU return [2XLEN-1:XLEN], negated as a 2*XLEN value when signs differ.
  - DIV negates the quotient when the operand signs differ.
  - REM takes the sign of the dividend.
  - Truncation is toward zero, per RISC-V.
- funct3 is fully decoded; there are no illegal encodings.

Optional Feature:
Macro: MULDIV_EARLY_OUT_EN.
- Defined: in S_CALC for MUL*, when the remaining unshifted multiplier bits are all 0, the unit finishes on that edge (sign correction, then S_DONE). Minimum normal MUL latency is 2 (b magnitude = 0, or b = 1 after the first bit). Divide latency is unchanged.
- Undefined: all non-special ops take exactly XLEN + 1 enabled edges. Results are identical in both builds.

Test Plan:
1. XLEN = 32, MUL a = 7, b = 0xFFFFFFFD -> result 0xFFFFFFEB. out_valid appears 33 edges after acceptance with the macro undefined; in_ready = 0 throughout.
2. MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
4. Special cases:
   - DIVU 0x1234 / 0 -> 0xFFFFFFFF with latency 2.
   - REM 0x1234 / 0 -> 0x1234.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000 / 0xFFFFFFFF -> 0.
5. Stall and backpressure:
   - Hold out_ready = 0 for 10 cycles: out_valid and result stay stable, in_ready = 0.
   - Drop ena for 5 cycles mid-S_CALC: latency becomes 38 and the result is unchanged.
6. Reset and parametrisation:
   - Assert rst at edge 10 of a DIV: next cycle shows in_ready = 1, out_valid = 0, result = 0. A new MUL 3 * 5 then returns 15.
   - Repeat scenarios 1 and 3 at XLEN = 8: MUL 7 * 0xFD -> 0xEB, latency 9.
   - With MULDIV_EARLY_OUT_EN defined, MUL 0x12345678 * 1 has latency 2.
